// File: rtl/mod_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_arith_pkg
//  Description : Mode and FSM state encodings shared by the modular
//                arithmetic datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package mod_arith_pkg;

    // Operation select values on i_mode; 2'b11 is reserved and yields zero
    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_ADD = 2'b01;
    localparam logic [1:0] MODE_SUB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MUL    = 2'd1,
        ST_ADDSUB = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : mod_arith_pkg
`default_nettype wire

// File: rtl/mod_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : mod_addsub
//  Description : Single-step modular add/subtract. Add returns x+y, minus n
//                when the (WIDTH+1)-bit sum reaches n; subtract returns x-y,
//                plus n when x < y. Inputs are assumed already reduced.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_addsub #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_n,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_r
);

    logic [WIDTH:0] w_sum;
    logic           w_ge;
    logic           w_borrow;

    // The carry bit lives only in the comparison; the final correction is
    // done modulo 2^WIDTH, which is exact because the true result is below n.
    assign w_sum    = {1'b0, i_x} + {1'b0, i_y};
    assign w_ge     = (w_sum >= {1'b0, i_n});
    assign w_borrow = (i_x < i_y);

    assign o_r = i_sub ? (i_x - i_y + (w_borrow ? i_n : '0))
                       : (w_sum[WIDTH-1:0] - (w_ge ? i_n : '0));

endmodule : mod_addsub
`default_nettype wire

// File: rtl/mod_mul_radix.sv
`default_nettype none
// ============================================================================
//  Module      : mod_mul_radix
//  Description : Constant-time modular multiply (LSB-first interleaved,
//                DIGIT_BITS multiplier bits per cycle) plus single-cycle
//                modular add/subtract.
//  Revision    : 1.0  initial release
// ============================================================================
module mod_mul_radix #(
    parameter int WIDTH      = 256,
    parameter int DIGIT_BITS = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);
    import mod_arith_pkg::*;

    localparam int              K        = WIDTH / DIGIT_BITS;
    localparam int              CNT_W    = $clog2(K + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q,  mode_d;
    logic [WIDTH-1:0] n_q,     n_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] m_q,     m_d;
    logic [WIDTH-1:0] t_q,     t_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] res_q,   res_d;

    logic [WIDTH-1:0] w_m_next;
    logic [WIDTH-1:0] w_t_next;
    logic [WIDTH-1:0] w_addsub;

    // One conditional-add plus one doubling per multiplier bit, chained so a
    // full digit is consumed per cycle. a_q is shifted right each cycle, so
    // the bits for this digit always sit at a_q[DIGIT_BITS-1:0].
    for (genvar j = 0; j < DIGIT_BITS; j++) begin : g_step
        logic [WIDTH-1:0] w_m_in;
        logic [WIDTH-1:0] w_t_in;
        logic [WIDTH-1:0] w_sum;
        logic [WIDTH-1:0] w_m_out;
        logic [WIDTH-1:0] w_t_out;

        if (j == 0) begin : g_head
            assign w_m_in = m_q;
            assign w_t_in = t_q;
        end else begin : g_link
            assign w_m_in = g_step[j-1].w_m_out;
            assign w_t_in = g_step[j-1].w_t_out;
        end

        mod_addsub #(.WIDTH(WIDTH)) u_acc (
            .i_x   (w_m_in),
            .i_y   (w_t_in),
            .i_n   (n_q),
            .i_sub (1'b0),
            .o_r   (w_sum)
        );

        mod_addsub #(.WIDTH(WIDTH)) u_dbl (
            .i_x   (w_t_in),
            .i_y   (w_t_in),
            .i_n   (n_q),
            .i_sub (1'b0),
            .o_r   (w_t_out)
        );

        // Both branches are always computed; the bit only steers a mux
        assign w_m_out = a_q[j] ? w_sum : w_m_in;
    end

    assign w_m_next = g_step[DIGIT_BITS-1].w_m_out;
    assign w_t_next = g_step[DIGIT_BITS-1].w_t_out;

    mod_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_x   (a_q),
        .i_y   (b_q),
        .i_n   (n_q),
        .i_sub (mode_q == MODE_SUB),
        .o_r   (w_addsub)
    );

    // Next-state and datapath update; everything holds unless a state acts
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        n_d     = n_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                // Start beats a simultaneous abort simply by abort being unused here
                if (i_start) begin
                    mode_d  = i_mode;
                    n_d     = i_n;
                    a_d     = i_a;
                    b_d     = i_b;
                    m_d     = '0;
                    t_d     = i_b;
                    cnt_d   = '0;
                    state_d = (i_mode == MODE_MUL) ? ST_MUL : ST_ADDSUB;
                end
            end
            ST_MUL: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    m_d   = w_m_next;
                    t_d   = w_t_next;
                    a_d   = a_q >> DIGIT_BITS;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        res_d   = w_m_next;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ADDSUB: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else begin
                    res_d   = (mode_q == MODE_ADD || mode_q == MODE_SUB) ? w_addsub : '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            n_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            t_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign o_busy   = (state_q != ST_IDLE);
    assign o_done   = (state_q == ST_DONE);
    assign o_result = res_q;

endmodule : mod_mul_radix
`default_nettype wire

// File: tb/tb_mod_mul_radix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_mul_radix
//  Description : Directed bench for mod_mul_radix: three 8-bit instances
//                (DIGIT_BITS 1, 2, 4) sharing stimulus, plus one 256-bit one.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mod_mul_radix;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] n;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] done8;
    logic [2:0] busy8;
    logic [7:0] res8 [0:2];

    logic         w_start;
    logic [1:0]   w_mode;
    logic [255:0] w_n;
    logic [255:0] w_a;
    logic [255:0] w_b;
    logic [255:0] w_res;
    logic         w_busy;
    logic         w_done;

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mod_mul_radix #(.WIDTH(8), .DIGIT_BITS(1 << k)) u_dut (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_start  (start),
            .i_abort  (abort),
            .i_mode   (mode),
            .i_n      (n),
            .i_a      (a),
            .i_b      (b),
            .o_busy   (busy8[k]),
            .o_done   (done8[k]),
            .o_result (res8[k])
        );
    end

    mod_mul_radix #(.WIDTH(256), .DIGIT_BITS(4)) u_wide (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (w_start),
        .i_abort  (1'b0),
        .i_mode   (w_mode),
        .i_n      (w_n),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_result (w_res)
    );

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called with start already high ahead of the accepting edge (cycle 0).
    // Scrambles the inputs right after acceptance to prove they were captured.
    task automatic collect(input vec_t v, input string tag);
        int dc [3];
        int np [3];
        int be [3];
        int lat;
        for (int k = 0; k < 3; k++) begin
            dc[k] = 0; np[k] = 0; be[k] = 0;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a = ~v.a; b = ~v.b; n = 8'd7; mode = ~v.mode;
            end
            for (int k = 0; k < 3; k++) begin
                lat = (v.mode == 2'b00) ? (8 >> k) + 1 : 2;
                if (done8[k]) begin
                    np[k]++;
                    if (dc[k] == 0) dc[k] = c;
                end
                if (busy8[k] !== (c <= lat)) be[k]++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            lat = (v.mode == 2'b00) ? (8 >> k) + 1 : 2;
            check($sformatf("%s d%0d result", tag, 1 << k), res8[k], v.exp);
            check($sformatf("%s d%0d done_cycle", tag, 1 << k), dc[k], lat);
            check($sformatf("%s d%0d done_pulses", tag, 1 << k), np[k], 1);
            check($sformatf("%s d%0d busy_window_errs", tag, 1 << k), be[k], 0);
        end
    endtask

    task automatic launch(input vec_t v, input string tag);
        @(negedge clk);
        mode = v.mode; n = v.n; a = v.a; b = v.b; start = 1'b1;
        collect(v, tag);
    endtask

    task automatic run_wide(input logic [1:0] md, input logic [255:0] nn, input logic [255:0] aa,
                            input logic [255:0] bb, input logic [255:0] exp, input int lat, input string tag);
        int dc;
        dc = 0;
        @(negedge clk);
        w_mode = md; w_n = nn; w_a = aa; w_b = bb; w_start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) w_start = 1'b0;
            if (w_done && dc == 0) dc = c;
        end
        check({tag, " result"}, w_res, exp);
        check({tag, " done_cycle"}, dc, lat);
    endtask

    vec_t tbl [16];

    initial begin
        vec_t v;
        int   dn;
        int   d1 [3];
        int   d2 [3];
        int   r1 [3];
        logic [255:0] big_n;

        tbl[0]  = '{2'b00, 8'd251, 8'd200, 8'd100, 8'd171};
        tbl[1]  = '{2'b01, 8'd251, 8'd200, 8'd100, 8'd49};
        tbl[2]  = '{2'b10, 8'd251, 8'd100, 8'd200, 8'd151};
        tbl[3]  = '{2'b00, 8'd251, 8'd250, 8'd250, 8'd1};
        tbl[4]  = '{2'b00, 8'd251, 8'd0,   8'd123, 8'd0};
        tbl[5]  = '{2'b00, 8'd251, 8'd1,   8'd77,  8'd77};
        tbl[6]  = '{2'b00, 8'd251, 8'd123, 8'd45,  8'd13};
        tbl[7]  = '{2'b00, 8'd251, 8'd250, 8'd2,   8'd249};
        tbl[8]  = '{2'b01, 8'd251, 8'd250, 8'd1,   8'd0};
        tbl[9]  = '{2'b10, 8'd251, 8'd0,   8'd250, 8'd1};
        tbl[10] = '{2'b10, 8'd251, 8'd5,   8'd5,   8'd0};
        tbl[11] = '{2'b11, 8'd251, 8'd3,   8'd4,   8'd0};
        tbl[12] = '{2'b00, 8'd13,  8'd7,   8'd9,   8'd11};
        tbl[13] = '{2'b01, 8'd2,   8'd1,   8'd1,   8'd0};
        tbl[14] = '{2'b00, 8'd255, 8'd254, 8'd254, 8'd1};
        tbl[15] = '{2'b01, 8'd255, 8'd254, 8'd254, 8'd253};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'b00; n = 8'd0; a = 8'd0; b = 8'd0;
        w_start = 1'b0; w_mode = 2'b00; w_n = '0; w_a = '0; w_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset d%0d busy", 1 << k), busy8[k], 1'b0);
            check($sformatf("reset d%0d done", 1 << k), done8[k], 1'b0);
            check($sformatf("reset d%0d result", 1 << k), res8[k], 8'd0);
        end
        check("reset wide result", w_res, 256'd0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) launch(tbl[i], $sformatf("vec%0d", i));

        // Abort during MUL cycle 3, previous result must survive
        v = '{2'b01, 8'd251, 8'd1, 8'd2, 8'd3};
        launch(v, "pre_abort");
        @(negedge clk);
        mode = 2'b00; n = 8'd251; a = 8'd7; b = 8'd9; start = 1'b1;
        dn = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 3) abort = 1'b1;
            if (c == 4) abort = 1'b0;
            if (done8[0] || done8[1]) dn++;
        end
        check("abort d1 busy", busy8[0], 1'b0);
        check("abort d2 busy", busy8[1], 1'b0);
        check("abort d1 result_held", res8[0], 8'd3);
        check("abort d2 result_held", res8[1], 8'd3);
        check("abort d4 completed_before", res8[2], 8'd63);
        check("abort no_done", dn, 0);
        // New start in the cycle right after the abort
        mode = 2'b00; n = 8'd251; a = 8'd200; b = 8'd100; start = 1'b1;
        collect(tbl[0], "post_abort");

        // Reset in the middle of a multiply
        @(negedge clk);
        mode = 2'b00; n = 8'd251; a = 8'd200; b = 8'd100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst d%0d busy", 1 << k), busy8[k], 1'b0);
            check($sformatf("midrst d%0d done", 1 << k), done8[k], 1'b0);
            check($sformatf("midrst d%0d result", 1 << k), res8[k], 8'd0);
        end
        dn = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done8 != 3'b000) dn++;
        end
        check("midrst no_done_after", dn, 0);

        // Start held high: busy-time starts ignored, back-to-back spacing K+2
        @(negedge clk);
        mode = 2'b00; n = 8'd251; a = 8'd200; b = 8'd100; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d1[k] = 0; d2[k] = 0; r1[k] = 0;
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 3) a = 8'd5;
            for (int k = 0; k < 3; k++) begin
                if (done8[k]) begin
                    if (d1[k] == 0) begin
                        d1[k] = c; r1[k] = int'(res8[k]);
                    end else if (d2[k] == 0) begin
                        d2[k] = c;
                    end
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b d%0d first_done", 1 << k), d1[k], (8 >> k) + 1);
            check($sformatf("b2b d%0d second_done", 1 << k), d2[k], 2 * (8 >> k) + 3);
            check($sformatf("b2b d%0d first_result", 1 << k), r1[k], 171);
        end
        repeat (20) @(negedge clk);

        // Full-width operands near 2^256
        big_n = '1;
        big_n = big_n - 256'd188;
        run_wide(2'b00, big_n, big_n - 256'd1, big_n - 256'd1, 256'd1, 65, "wide mul");
        run_wide(2'b01, big_n, big_n - 256'd1, big_n - 256'd1, big_n - 256'd2, 2, "wide add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mod_mul_radix
`default_nettype wire
